mdu_iterative: RTL and testbench

- RV32M multiply/divide unit in the EX stage.
- Iterative shift-add multiplier and restoring divider share one 64-bit working datapath.
- Drives the pipeline hazard unit's M-type stall input: PC, IF/ID and ID/EX hold while an M op iterates.
- Result returns to the EX result mux in the cycle the stall drops.

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mdu_shift_core.sv | 65 ++++++
 rtl/mdu_iterative.sv | 139 +++++++++++++
 tb/tb_mdu_iterative.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared constants for the RV32M multiply/divide unit: funct3 codes, FSM encodings, XLEN.
package mdu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic [XLEN-1:0] negate_if(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mdu_shift_core.sv
// Shared 64-bit shift datapath: one shift-add multiply or restoring divide step per cycle.
module mdu_shift_core #(
    parameter int XLEN = mdu_pkg::XLEN,
    parameter int ITER = XLEN
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_load,
    input  logic              i_step,
    input  logic              i_clear,
    input  logic              i_div,
    input  logic [XLEN-1:0]   i_lo,
    input  logic [XLEN-1:0]   i_operand,
    output logic [2*XLEN-1:0] o_work,
    output logic              o_last
);
    localparam int CW = $clog2(ITER + 1);

    logic [2*XLEN-1:0] r_work;
    logic [XLEN-1:0]   r_operand;
    logic              r_div;
    logic [CW-1:0]     r_count;

    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shl_hi;
    logic [XLEN+1:0]   w_diff;
    logic              w_ge;
    logic [2*XLEN-1:0] w_mul_next;
    logic [2*XLEN-1:0] w_div_next;

    // Multiply: add multiplicand into the upper half on a set LSB, then shift right (carry kept).
    always_comb begin
        w_sum      = {1'b0, r_work[2*XLEN-1:XLEN]} + (r_work[0] ? {1'b0, r_operand} : '0);
        w_mul_next = {w_sum, r_work[XLEN-1:1]};
    end

    // Divide: shifted partial remainder needs XLEN+1 bits before the trial subtract.
    always_comb begin
        w_shl_hi   = r_work[2*XLEN-1:XLEN-1];
        w_diff     = {1'b0, w_shl_hi} - {2'b00, r_operand};
        w_ge       = ~w_diff[XLEN+1];
        w_div_next = {(w_ge ? w_diff[XLEN-1:0] : w_shl_hi[XLEN-1:0]), r_work[XLEN-2:0], w_ge};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || i_clear) begin
            r_work    <= '0;
            r_operand <= '0;
            r_div     <= 1'b0;
            r_count   <= '0;
        end else if (i_load) begin
            r_work    <= {{XLEN{1'b0}}, i_lo};
            r_operand <= i_operand;
            r_div     <= i_div;
            r_count   <= CW'(ITER);
        end else if (i_step) begin
            r_work    <= r_div ? w_div_next : w_mul_next;
            r_count   <= r_count - 1'b1;
        end
    end

    assign o_work = r_work;
    assign o_last = (r_count == CW'(1));

endmodule

// File: rtl/mdu_iterative.sv
// RV32M multiply/divide unit: FSM, sign handling, special cases and result mux.
// Optional macro MDU_FAST_MUL_EN: single-cycle combinational multiplies, no stall.
module mdu_iterative #(
    parameter int XLEN = mdu_pkg::XLEN,
    parameter int ITER = XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic            flush_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);
    import mdu_pkg::*;

    logic [1:0]      r_state;
    logic [2:0]      r_funct3;
    logic            r_neg_a;
    logic            r_neg_b;
    logic            r_special;
    logic [XLEN-1:0] r_special_res;

    logic              w_live, w_start, w_fast, w_is_div;
    logic              w_a_signed, w_b_signed, w_neg_a, w_neg_b;
    logic [XLEN-1:0]   w_mag_a, w_mag_b;
    logic              w_div_zero, w_ovf, w_special;
    logic [XLEN-1:0]   w_special_res;
    logic [2*XLEN-1:0] w_work, w_prod;
    logic [XLEN-1:0]   w_quo, w_rem, w_iter_res, w_fast_res;
    logic              w_last;

    assign w_live     = ~rst_i & ~flush_i;
    assign w_is_div   = funct3_i[2];
    assign w_start    = w_live & valid_i & (r_state == S_IDLE);
    assign w_a_signed = (funct3_i == MDU_MULH) | (funct3_i == MDU_MULHSU) |
                        (funct3_i == MDU_DIV)  | (funct3_i == MDU_REM);
    assign w_b_signed = (funct3_i == MDU_MULH) | (funct3_i == MDU_DIV) | (funct3_i == MDU_REM);
    assign w_neg_a    = w_a_signed & rs1_i[XLEN-1];
    assign w_neg_b    = w_b_signed & rs2_i[XLEN-1];
    assign w_mag_a    = negate_if(rs1_i, w_neg_a);
    assign w_mag_b    = negate_if(rs2_i, w_neg_b);

    // Divide-by-zero and the single signed-overflow pair bypass the datapath.
    assign w_div_zero = w_is_div & (rs2_i == '0);
    assign w_ovf      = ((funct3_i == MDU_DIV) | (funct3_i == MDU_REM)) &
                        (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_i == '1);
    assign w_special  = w_div_zero | w_ovf;
    always_comb begin
        w_special_res = '0;
        if (w_div_zero)
            w_special_res = funct3_i[1] ? rs1_i : '1;
        else if (w_ovf)
            w_special_res = funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_a, w_fast_b, w_fast_prod;
    // Sign-extending to 64 bits is the 33x33 signed product taken modulo 2^64.
    assign w_fast_a    = {{XLEN{w_a_signed & rs1_i[XLEN-1]}}, rs1_i};
    assign w_fast_b    = {{XLEN{w_b_signed & rs2_i[XLEN-1]}}, rs2_i};
    assign w_fast_prod = w_fast_a * w_fast_b;
    assign w_fast      = w_start & ~w_is_div;
    assign w_fast_res  = (funct3_i == MDU_MUL) ? w_fast_prod[XLEN-1:0] : w_fast_prod[2*XLEN-1:XLEN];
`else
    assign w_fast      = 1'b0;
    assign w_fast_res  = '0;
`endif

    mdu_shift_core #(.XLEN(XLEN), .ITER(ITER)) u_core (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_load    (w_start & ~w_fast & ~w_special),
        .i_step    (w_live & (r_state == S_BUSY)),
        .i_clear   (flush_i),
        .i_div     (w_is_div),
        .i_lo      (w_mag_a),
        .i_operand (w_mag_b),
        .o_work    (w_work),
        .o_last    (w_last)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_funct3      <= '0;
            r_neg_a       <= 1'b0;
            r_neg_b       <= 1'b0;
            r_special     <= 1'b0;
            r_special_res <= '0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start && !w_fast) begin
                        r_state       <= w_special ? S_DONE : S_BUSY;
                        r_funct3      <= funct3_i;
                        r_neg_a       <= w_neg_a;
                        r_neg_b       <= w_neg_b;
                        r_special     <= w_special;
                        r_special_res <= w_special_res;
                    end
                end
                S_BUSY:  if (w_last) r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Product negated as a full 64-bit value; remainder follows the dividend's sign.
    assign w_prod = (r_neg_a ^ r_neg_b) ? (~w_work + 1'b1) : w_work;
    assign w_quo  = negate_if(w_work[XLEN-1:0], r_neg_a ^ r_neg_b);
    assign w_rem  = negate_if(w_work[2*XLEN-1:XLEN], r_neg_a);

    always_comb begin
        case (r_funct3)
            MDU_MUL:                        w_iter_res = w_prod[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: w_iter_res = w_prod[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:              w_iter_res = w_quo;
            default:                        w_iter_res = w_rem;
        endcase
    end

    assign stall_o  = w_live & (((r_state == S_IDLE) & valid_i & ~w_fast) | (r_state == S_BUSY));
    assign done_o   = w_live & ((r_state == S_DONE) | w_fast);
    assign busy_o   = (r_state != S_IDLE);

    always_comb begin
        result_o = '0;
        if (done_o)
            result_o = w_fast ? w_fast_res : (r_special ? r_special_res : w_iter_res);
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed RV32M cases, random ops vs. arithmetic model.
module tb_mdu_iterative;
    logic        clk = 1'b0;
    logic        rst_i, valid_i, flush_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i, rs2_i;
    logic        stall_o, done_o, busy_o;
    logic [31:0] result_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mdu_iterative dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .flush_i  (flush_i),
        .funct3_i (funct3_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o),
        .busy_o   (busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'h0, a});
        longint ub = longint'({32'h0, b});
        logic   ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        logic [63:0] p;
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_stalls(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic ovf = (f3 == 3'd4 || f3 == 3'd6) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (f3[2] && (b == 0 || ovf)) return 1;
`ifdef MDU_FAST_MUL_EN
        if (!f3[2]) return 0;
`endif
        return 33;
    endfunction

    // Leaves valid_i asserted so consecutive calls issue back-to-back ops.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string tag);
        int stalls = 0;
        int cyc = 0;
        logic got_done = 1'b0;
        logic clean = 1'b1;
        logic [31:0] res = 32'h0;
        int es = exp_stalls(f3, a, b);
        @(negedge clk);
        valid_i = 1'b1; funct3_i = f3; rs1_i = a; rs2_i = b;
        #1;
        chk({tag, " idle_at_issue"}, {31'h0, busy_o}, 32'h0);
        while (cyc < 100) begin
            cyc++;
            if (done_o) begin got_done = 1'b1; res = result_o; break; end
            if (stall_o) stalls++;
            if (result_o !== 32'h0) clean = 1'b0;
            @(negedge clk);
            #1;
        end
        chk({tag, " done_seen"}, {31'h0, got_done}, 32'h1);
        chk({tag, " stalls"}, stalls, es);
        chk({tag, " done_cycle"}, cyc, es + 1);
        chk({tag, " result"}, res, model(f3, a, b));
        chk({tag, " result_zero_before_done"}, {31'h0, clean}, 32'h1);
        $display("[TB] %s f3=%0d a=%h b=%h result=%h stalls=%0d done_cycle=%0d", tag, f3, a, b, res, stalls, cyc);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    initial begin
        int dones;
        logic [31:0] pool [6];
        pool[0] = 32'h0; pool[1] = 32'hFFFF_FFFF; pool[2] = 32'h8000_0000;
        pool[3] = 32'h7FFF_FFFF; pool[4] = 32'h1; pool[5] = 32'hFFFF_FFF9;

        rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; funct3_i = 3'd0; rs1_i = 0; rs2_i = 0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        #1;
        chk("reset stall", {31'h0, stall_o}, 32'h0);
        chk("reset done", {31'h0, done_o}, 32'h0);
        chk("reset result", result_o, 32'h0);
        chk("reset busy", {31'h0, busy_o}, 32'h0);
        $display("[TB] reset released");

        run_op(3'd0, 32'd7, 32'd6, "MUL 7x6");
        idle_cycle();
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, "MULH");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHSU");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHU");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "DIV -7/2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "REM -7/2");
        run_op(3'd5, 32'd100, 32'd7, "DIVU 100/7");
        run_op(3'd7, 32'd100, 32'd7, "REMU 100/7");
        run_op(3'd4, 32'd5, 32'd0, "DIV 5/0");
        run_op(3'd6, 32'd5, 32'd0, "REM 5/0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "DIV ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "REM ovf");
        run_op(3'd5, 32'd1000, 32'd3, "DIVU b2b#1");
        run_op(3'd5, 32'hDEAD_BEEF, 32'd17, "DIVU b2b#2");
        idle_cycle();

        // Flush at iteration 10 of a divide.
        @(negedge clk);
        valid_i = 1'b1; funct3_i = 3'd5; rs1_i = 32'd1000; rs2_i = 32'd3;
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        #1;
        chk("flush stall", {31'h0, stall_o}, 32'h0);
        chk("flush done", {31'h0, done_o}, 32'h0);
        chk("flush result", result_o, 32'h0);
        @(negedge clk);
        flush_i = 1'b0; valid_i = 1'b0;
        #1;
        chk("flush idle", {31'h0, busy_o}, 32'h0);
        dones = 0;
        repeat (40) begin @(negedge clk); #1; if (done_o) dones++; end
        chk("flush no_done", dones, 0);
        $display("[TB] flush at iteration 10 done_pulses_after=%0d", dones);

        // Reset at iteration 20 of a divide.
        @(negedge clk);
        valid_i = 1'b1; funct3_i = 3'd4; rs1_i = 32'h1234_5678; rs2_i = 32'd9;
        repeat (20) @(negedge clk);
        rst_i = 1'b1; valid_i = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst stall", {31'h0, stall_o}, 32'h0);
        chk("midrst done", {31'h0, done_o}, 32'h0);
        chk("midrst result", result_o, 32'h0);
        chk("midrst busy", {31'h0, busy_o}, 32'h0);
        rst_i = 1'b0;
        dones = 0;
        repeat (40) begin @(negedge clk); #1; if (done_o) dones++; end
        chk("midrst no_done", dones, 0);
        $display("[TB] reset at iteration 20 done_pulses_after=%0d", dones);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3 = 3'($urandom_range(0, 7));
            logic [31:0] a  = $urandom;
            logic [31:0] b  = $urandom;
            if ($urandom_range(0, 3) == 0) a = pool[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) == 0) b = pool[$urandom_range(0, 5)];
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(1, 28);
            run_op(f3, a, b, $sformatf("rand%0d", i));
            if ($urandom_range(0, 1) == 0) idle_cycle();
        end
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
